// File: rtl/traffic_intersection.sv
// Two-approach (NS/EW) intersection controller with all-red clearance,
// latched pedestrian request with early green cut-off and a walk phase,
// and a flashing-yellow night mode. Lamps are a Moore decode of the state.
module traffic_intersection #(
  parameter longint unsigned GREEN_CYCLES      = 64'd2500000000,
  parameter longint unsigned YELLOW_CYCLES     = 64'd250000000,
  parameter longint unsigned ALL_RED_CYCLES    = 64'd50000000,
  parameter longint unsigned MIN_GREEN_CYCLES  = 64'd500000000,
  parameter longint unsigned WALK_CYCLES       = 64'd350000000,
  parameter longint unsigned FLASH_HALF_CYCLES = 64'd25000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ped_req,
  input  logic       flash_en,
  output logic       ns_red,
  output logic       ns_yellow,
  output logic       ns_green,
  output logic       ew_red,
  output logic       ew_yellow,
  output logic       ew_green,
  output logic       walk,
  output logic       ped_pending,
  output logic [2:0] phase
);

  // Counter width covers the longest timed phase, with one spare bit.
  localparam longint unsigned MAX_GY  = (GREEN_CYCLES > YELLOW_CYCLES) ? GREEN_CYCLES : YELLOW_CYCLES;
  localparam longint unsigned MAX_AR  = (MAX_GY > ALL_RED_CYCLES) ? MAX_GY : ALL_RED_CYCLES;
  localparam longint unsigned MAX_MG  = (MAX_AR > MIN_GREEN_CYCLES) ? MAX_AR : MIN_GREEN_CYCLES;
  localparam longint unsigned MAX_WK  = (MAX_MG > WALK_CYCLES) ? MAX_MG : WALK_CYCLES;
  localparam longint unsigned MAX_T   = (MAX_WK > FLASH_HALF_CYCLES) ? MAX_WK : FLASH_HALF_CYCLES;
  localparam int              CNT_W   = $clog2(MAX_T) + 1;

  // Terminal counts: a phase of N cycles leaves on the edge where cnt == N-1.
  localparam logic [CNT_W-1:0] GREEN_LAST     = CNT_W'(GREEN_CYCLES - 64'd1);
  localparam logic [CNT_W-1:0] YELLOW_LAST    = CNT_W'(YELLOW_CYCLES - 64'd1);
  localparam logic [CNT_W-1:0] ALL_RED_LAST   = CNT_W'(ALL_RED_CYCLES - 64'd1);
  localparam logic [CNT_W-1:0] MIN_GREEN_LAST = CNT_W'(MIN_GREEN_CYCLES - 64'd1);
  localparam logic [CNT_W-1:0] WALK_LAST      = CNT_W'(WALK_CYCLES - 64'd1);
  localparam logic [CNT_W-1:0] FLASH_LAST     = CNT_W'(FLASH_HALF_CYCLES - 64'd1);

  typedef enum logic [2:0] {
    NS_GREEN  = 3'd0,
    NS_YELLOW = 3'd1,
    ALL_RED_A = 3'd2,
    EW_GREEN  = 3'd3,
    EW_YELLOW = 3'd4,
    ALL_RED_B = 3'd5,
    PED_WALK  = 3'd6,
    FLASH     = 3'd7
  } state_t;

  typedef enum logic {
    DIR_NS = 1'b0,
    DIR_EW = 1'b1
  } dir_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  dir_t             next_dir_q, next_dir_d;
  logic             ped_pending_q, ped_pending_d;
  logic             flash_tog_q, flash_tog_d;

  // A press arriving on the threshold cycle itself still cuts green short.
  logic ped_any;
  assign ped_any = ped_pending_q | ped_req;

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ALL_RED_B;
      cnt_q         <= '0;
      next_dir_q    <= DIR_NS;
      ped_pending_q <= 1'b0;
      flash_tog_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      next_dir_q    <= next_dir_d;
      ped_pending_q <= ped_pending_d;
      flash_tog_q   <= flash_tog_d;
    end
  end

  // Next-state logic: timed sequence, early green exit, all-red priority.
  always_comb begin
    state_d    = state_q;
    next_dir_d = next_dir_q;
    case (state_q)
      NS_GREEN: begin
        if (cnt_q == GREEN_LAST || (ped_any && cnt_q >= MIN_GREEN_LAST)) state_d = NS_YELLOW;
      end
      NS_YELLOW: begin
        if (cnt_q == YELLOW_LAST) state_d = ALL_RED_A;
      end
      ALL_RED_A: begin
        if (cnt_q == ALL_RED_LAST) begin
          next_dir_d = DIR_EW;
          if (flash_en)           state_d = FLASH;
          else if (ped_pending_q) state_d = PED_WALK;
          else                    state_d = EW_GREEN;
        end
      end
      EW_GREEN: begin
        if (cnt_q == GREEN_LAST || (ped_any && cnt_q >= MIN_GREEN_LAST)) state_d = EW_YELLOW;
      end
      EW_YELLOW: begin
        if (cnt_q == YELLOW_LAST) state_d = ALL_RED_B;
      end
      ALL_RED_B: begin
        if (cnt_q == ALL_RED_LAST) begin
          next_dir_d = DIR_NS;
          if (flash_en)           state_d = FLASH;
          else if (ped_pending_q) state_d = PED_WALK;
          else                    state_d = NS_GREEN;
        end
      end
      PED_WALK: begin
        // Walk already holds both approaches red, so no extra clearance.
        if (cnt_q == WALK_LAST) state_d = (next_dir_q == DIR_EW) ? EW_GREEN : NS_GREEN;
      end
      FLASH: begin
        if (!flash_en) state_d = ALL_RED_B;
      end
      default: state_d = ALL_RED_B;
    endcase
  end

  // Phase counter, flash toggle and pedestrian latch.
  always_comb begin
    cnt_d       = cnt_q + CNT_W'(1);
    flash_tog_d = flash_tog_q;
    if (state_d != state_q) begin
      cnt_d = '0;
      if (state_d == FLASH) flash_tog_d = 1'b1;
    end else if (state_q == FLASH && cnt_q == FLASH_LAST) begin
      // In flash the counter times half-periods and wraps.
      cnt_d       = '0;
      flash_tog_d = ~flash_tog_q;
    end
    // The request is consumed as walk begins; presses during walk are dropped.
    ped_pending_d = ped_any & (state_d != PED_WALK);
  end

  // Moore lamp decode of the registered state.
  always_comb begin
    ns_red    = 1'b1;
    ns_yellow = 1'b0;
    ns_green  = 1'b0;
    ew_red    = 1'b1;
    ew_yellow = 1'b0;
    ew_green  = 1'b0;
    walk      = 1'b0;
    case (state_q)
      NS_GREEN:  begin ns_red = 1'b0; ns_green  = 1'b1; end
      NS_YELLOW: begin ns_red = 1'b0; ns_yellow = 1'b1; end
      EW_GREEN:  begin ew_red = 1'b0; ew_green  = 1'b1; end
      EW_YELLOW: begin ew_red = 1'b0; ew_yellow = 1'b1; end
      PED_WALK:  walk = 1'b1;
      FLASH: begin
        ns_red    = 1'b0;
        ew_red    = 1'b0;
        ns_yellow = flash_tog_q;
        ew_yellow = flash_tog_q;
      end
      default: ;
    endcase
  end

  assign ped_pending = ped_pending_q;
  assign phase       = state_q;

endmodule
